// File: rtl/pq_pkg.sv
// Shared definitions for the priority-queue batch controller: state encoding,
// default queue depth and the occupancy counter width helper.
package pq_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } pq_state_t;

  localparam int PQ_DEPTH = 6;

  // Bits needed to hold an occupancy value in 0..depth inclusive.
  function automatic int pq_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pq_batch_reader.sv
// Consumer-side controller for the sorted priority queue: collects a batch from
// an upstream stream, then drains it largest-first with a last marker.
module pq_batch_reader
  import pq_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = PQ_DEPTH
) (
  input  logic                       ck,
  input  logic                       r,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [W-1:0]               in_data,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [W-1:0]               out_data,
  output logic                       out_last,
  input  logic                       out_ready,
  output logic [W-1:0]               pq_newVal,
  output logic                       pq_loadIn,
  output logic                       pq_shiftOut,
  output logic                       pq_clear,
  input  logic [W-1:0]               pq_top,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = pq_cnt_w(DEPTH);

  pq_state_t      state_reg, state_next;
  logic [CW-1:0]  count_reg, count_next;
  logic [CW-1:0]  post_cnt;

  assign pq_newVal = in_data;
  assign out_data  = pq_top;
  assign count     = count_reg;

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    post_cnt    = count_reg;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    pq_loadIn   = 1'b0;
    pq_shiftOut = 1'b0;
    pq_clear    = 1'b0;

    if (r) begin
      // The queue is held in reset by the same r; only advertise readiness.
      in_ready = 1'b1;
    end else if (flush) begin
      pq_clear   = 1'b1;
      count_next = '0;
      state_next = FILL;
    end else begin
      case (state_reg)
        FILL: begin
          in_ready = (count_reg < CW'(DEPTH));
          if (in_valid && in_ready) begin
            // Zero is the queue's empty marker, so it is consumed but never stored.
            pq_loadIn  = (in_data != '0);
            post_cnt   = count_reg + CW'(pq_loadIn);
            count_next = post_cnt;
            if ((in_last && (post_cnt != '0)) || (post_cnt == CW'(DEPTH)))
              state_next = DRAIN;
          end
        end
        DRAIN: begin
          out_valid = 1'b1;
          out_last  = (count_reg == CW'(1));
          if (out_ready) begin
            pq_shiftOut = 1'b1;
            count_next  = count_reg - CW'(1);
            if (count_reg == CW'(1))
              state_next = FILL;
          end
        end
      endcase
    end
  end

  always_ff @(posedge ck or posedge r) begin
    if (r) begin
      state_reg <= FILL;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

endmodule

// File: tb/tb_pq_batch_reader.sv
// Bench for pq_batch_reader: behavioural sorted queue on the pq_* side plus a
// multiset reference model of batch fill/drain, directed steps then random traffic.
module tb_pq_batch_reader;

  typedef logic [7:0] qarr_t [6];

  logic       ck = 1'b0;
  logic       r = 1'b1;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready = 1'b0;
  logic [7:0] pq_newVal;
  logic       pq_loadIn;
  logic       pq_shiftOut;
  logic       pq_clear;
  logic [7:0] pq_top;
  logic [2:0] count;

  int vectors = 0;
  int miscompares = 0;

  pq_batch_reader #(.W(8), .DEPTH(6)) dut (
    .ck(ck), .r(r), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .pq_newVal(pq_newVal), .pq_loadIn(pq_loadIn), .pq_shiftOut(pq_shiftOut),
    .pq_clear(pq_clear), .pq_top(pq_top), .count(count)
  );

  always #5 ck = ~ck;

  // Behavioural 6-entry sorted queue; equal values land below existing ones.
  qarr_t qm;
  assign pq_top = qm[0];

  function automatic qarr_t q_ins(input qarr_t a, input logic [7:0] v);
    qarr_t b;
    int p = 6;
    for (int i = 0; i < 6; i++)
      if (p == 6 && v > a[i]) p = i;
    for (int i = 0; i < 6; i++)
      b[i] = (i < p) ? a[i] : (i == p) ? v : a[i-1];
    return b;
  endfunction

  function automatic qarr_t q_shift(input qarr_t a);
    qarr_t b;
    for (int i = 0; i < 5; i++) b[i] = a[i+1];
    b[5] = 8'd0;
    return b;
  endfunction

  always @(posedge ck or posedge r) begin
    if (r)                qm <= '{default: 8'd0};
    else if (pq_clear)    qm <= '{default: 8'd0};
    else if (pq_loadIn)   qm <= q_ins(qm, pq_newVal);
    else if (pq_shiftOut) qm <= q_shift(qm);
  end

  // Reference model: multiset of stored values and a draining flag.
  int ref_q[$];
  bit drain = 1'b0;
  int got[$];

  function automatic int ref_max();
    int m = 0;
    foreach (ref_q[i]) if (ref_q[i] > m) m = ref_q[i];
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always begin
    @(negedge ck);
    #3;
    if (!r) begin
      vectors++;
      assert (!(pq_loadIn && pq_shiftOut))
      else begin
        miscompares++;
        $error("FAIL exclusion: observed loadIn=%0b shiftOut=%0b expected not both", pq_loadIn, pq_shiftOut);
      end
      vectors++;
      assert (count <= 3'd6)
      else begin
        miscompares++;
        $error("FAIL count_range: observed %0d expected <=6", count);
      end
    end
  end

  // Check one cycle against the model, then advance the model over the edge.
  task automatic cycle();
    bit exp_ir, exp_ov, exp_li, exp_so;
    int idx;
    #1;
    if (r) begin
      ref_q.delete();
      drain = 1'b0;
    end
    exp_ir = r ? 1'b1 : (!drain && ref_q.size() < 6 && !flush);
    exp_ov = !r && drain && !flush;
    exp_li = !r && !flush && in_valid && exp_ir && (in_data != 8'd0);
    exp_so = exp_ov && out_ready;
    chk("in_ready", 32'(in_ready), 32'(exp_ir));
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    chk("out_last", 32'(out_last), 32'(exp_ov && ref_q.size() == 1));
    chk("pq_loadIn", 32'(pq_loadIn), 32'(exp_li));
    chk("pq_shiftOut", 32'(pq_shiftOut), 32'(exp_so));
    chk("pq_clear", 32'(pq_clear), 32'(flush && !r));
    chk("count", 32'(count), 32'(ref_q.size()));
    if (exp_li) chk("pq_newVal", 32'(pq_newVal), 32'(in_data));
    if (exp_ov) chk("out_data", 32'(out_data), 32'(ref_max()));
    if (out_valid && out_ready) got.push_back(int'(out_data));
    $display("t=%0t r=%0b fl=%0b iv=%0b id=%0d il=%0b ir=%0b ov=%0b od=%0d ol=%0b or=%0b cnt=%0d",
             $time, r, flush, in_valid, in_data, in_last, in_ready, out_valid, out_data,
             out_last, out_ready, count);
    if (!r) begin
      if (flush) begin
        ref_q.delete();
        drain = 1'b0;
      end else if (!drain) begin
        if (in_valid && ref_q.size() < 6) begin
          if (in_data != 8'd0) ref_q.push_back(int'(in_data));
          if ((in_last && ref_q.size() > 0) || ref_q.size() == 6) drain = 1'b1;
        end
      end else if (out_ready) begin
        idx = 0;
        foreach (ref_q[i]) if (ref_q[i] > ref_q[idx]) idx = i;
        ref_q.delete(idx);
        if (ref_q.size() == 0) drain = 1'b0;
      end
    end
    @(posedge ck);
    @(negedge ck);
  endtask

  task automatic push(input logic [7:0] v, input logic last);
    in_valid = 1'b1;
    in_data  = v;
    in_last  = last;
    cycle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain_all(input bit toggle);
    for (int k = 0; k < 40 && drain; k++) begin
      out_ready = toggle ? (k % 2 == 0) : 1'b1;
      cycle();
    end
    out_ready = 1'b0;
    cycle();
  endtask

  task automatic check_got(input string tag, input int e[$]);
    chk({tag, "_len"}, 32'(got.size()), 32'(e.size()));
    foreach (e[i])
      if (i < got.size()) chk(tag, 32'(got[i]), 32'(e[i]));
    got.delete();
  endtask

  initial begin
    @(negedge ck);
    cycle();
    cycle();
    r = 1'b0;
    cycle();

    got.delete();
    push(8'd42, 0); push(8'd7, 0); push(8'd99, 0); push(8'd13, 1);
    drain_all(0);
    check_got("t1_order", '{99, 42, 13, 7});

    for (int i = 1; i <= 6; i++) push(8'(i * 10), 0);
    push(8'd70, 0);
    drain_all(0);
    check_got("t2_order", '{60, 50, 40, 30, 20, 10});

    push(8'd5, 0); push(8'd0, 0); push(8'd5, 0); push(8'd7, 1);
    chk("t3_count", 32'(count), 32'd3);
    drain_all(0);
    check_got("t3_order", '{7, 5, 5});

    push(8'd21, 0); push(8'd84, 0); push(8'd63, 0); push(8'd42, 1);
    drain_all(1);
    check_got("t4_order", '{84, 63, 42, 21});

    push(8'd11, 0); push(8'd22, 0); push(8'd33, 0);
    flush = 1'b1; cycle(); flush = 1'b0;
    cycle();
    chk("t5_top_cleared", 32'(pq_top), 32'd0);
    push(8'd3, 0); push(8'd1, 1);
    drain_all(0);
    check_got("t5_order", '{3, 1});

    push(8'd9, 0); push(8'd4, 0); push(8'd6, 0); push(8'd2, 1);
    cycle();
    r = 1'b1; cycle();
    r = 1'b0; cycle();
    chk("t6_count_after_reset", 32'(count), 32'd0);
    got.delete();
    push(8'd8, 1);
    drain_all(0);
    check_got("t6_order", '{8});

    for (int k = 0; k < 3000; k++) begin
      r         = ($urandom_range(0, 299) == 0);
      flush     = ($urandom_range(0, 49) == 0);
      in_valid  = $urandom_range(0, 1);
      in_data   = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      in_last   = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    r = 1'b0; flush = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
